// File: rtl/alu_op_sequencer.sv
// Command/response front end for the N-bit ALU; multiply runs as iterative shift-add through ALU add.
// Optional macro ALU_SEQ_ERR_EN adds rsp_err, flagging the reserved opcode 7.
module alu_op_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_q,
  output logic         rsp_zero,
`ifdef ALU_SEQ_ERR_EN
  output logic         rsp_err,
`endif
  output logic         busy,
  output logic [2:0]   alu_sel,
  output logic [N-1:0] alu_op1,
  output logic [N-1:0] alu_op2,
  input  logic [N-1:0] alu_q
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state_r;
  logic [N-1:0]   acc_r;
  logic [N-1:0]   m_r;
  logic [N-1:0]   r_r;
  logic [CW-1:0]  cnt_r;
  logic [N-1:0]   acc_n_s;
  logic           mul_last_s;
`ifdef ALU_SEQ_ERR_EN
  logic           err_pend_r;
`endif

  assign cmd_ready = (state_r == IDLE) && !rst;
  assign busy      = (state_r != IDLE);

  // Next accumulator value and multiply termination for the current MUL step
  always_comb begin
    acc_n_s    = acc_r;
    mul_last_s = 1'b0;
    if (r_r[0]) begin
      acc_n_s = alu_q;
    end else begin
      acc_n_s = acc_r;
    end
    if (((r_r >> 1) == {N{1'b0}}) || (cnt_r == CW'(N - 1))) begin
      mul_last_s = 1'b1;
    end else begin
      mul_last_s = 1'b0;
    end
  end

  // Sequencer FSM with registered ALU drive and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      acc_r     <= {N{1'b0}};
      m_r       <= {N{1'b0}};
      r_r       <= {N{1'b0}};
      cnt_r     <= {CW{1'b0}};
      rsp_valid <= 1'b0;
      rsp_q     <= {N{1'b0}};
      rsp_zero  <= 1'b1;
      alu_sel   <= 3'd0;
      alu_op1   <= {N{1'b0}};
      alu_op2   <= {N{1'b0}};
`ifdef ALU_SEQ_ERR_EN
      err_pend_r <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == 3'd2) begin
              // Multiply: first step adds m=a onto acc=0
              state_r <= MUL;
              acc_r   <= {N{1'b0}};
              m_r     <= cmd_a;
              r_r     <= cmd_b;
              cnt_r   <= {CW{1'b0}};
              alu_sel <= 3'd0;
              alu_op1 <= {N{1'b0}};
              alu_op2 <= cmd_a;
`ifdef ALU_SEQ_ERR_EN
              err_pend_r <= 1'b0;
`endif
            end else begin
              state_r <= EXEC;
              alu_sel <= (cmd_op == 3'd7) ? 3'd0 : cmd_op;
              alu_op1 <= cmd_a;
              alu_op2 <= cmd_b;
`ifdef ALU_SEQ_ERR_EN
              err_pend_r <= (cmd_op == 3'd7);
`endif
            end
          end
        end
        EXEC: begin
          state_r   <= RESP;
          rsp_valid <= 1'b1;
          rsp_q     <= alu_q;
          rsp_zero  <= (alu_q == {N{1'b0}});
          alu_sel   <= 3'd0;
          alu_op1   <= {N{1'b0}};
          alu_op2   <= {N{1'b0}};
`ifdef ALU_SEQ_ERR_EN
          rsp_err   <= err_pend_r;
`endif
        end
        MUL: begin
          acc_r <= acc_n_s;
          m_r   <= m_r << 1;
          r_r   <= r_r >> 1;
          cnt_r <= cnt_r + CW'(1);
          if (mul_last_s) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_q     <= acc_n_s;
            rsp_zero  <= (acc_n_s == {N{1'b0}});
            alu_sel   <= 3'd0;
            alu_op1   <= {N{1'b0}};
            alu_op2   <= {N{1'b0}};
`ifdef ALU_SEQ_ERR_EN
            rsp_err   <= 1'b0;
`endif
          end else begin
            alu_sel <= 3'd0;
            alu_op1 <= acc_n_s;
            alu_op2 <= m_r << 1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
          alu_sel   <= 3'd0;
          alu_op1   <= {N{1'b0}};
          alu_op2   <= {N{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU and result/latency model.
module tb_alu_op_sequencer;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_q;
  logic         rsp_zero;
`ifdef ALU_SEQ_ERR_EN
  logic         rsp_err;
`endif
  logic         busy;
  logic [2:0]   alu_sel;
  logic [N-1:0] alu_op1;
  logic [N-1:0] alu_op2;
  logic [N-1:0] alu_q;

  int n_cmp;
  int n_err;

  alu_op_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_q     (rsp_q),
    .rsp_zero  (rsp_zero),
`ifdef ALU_SEQ_ERR_EN
    .rsp_err   (rsp_err),
`endif
    .busy      (busy),
    .alu_sel   (alu_sel),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_q     (alu_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU the sequencer drives
  always_comb begin
    alu_q = '0;
    case (alu_sel)
      3'd0:    alu_q = alu_op1 + alu_op2;
      3'd1:    alu_q = alu_op1 - alu_op2;
      3'd2:    alu_q = alu_op1 * alu_op2;
      3'd3:    alu_q = alu_op1 >> alu_op2;
      3'd4:    alu_q = alu_op1 & alu_op2;
      3'd5:    alu_q = alu_op1 | alu_op2;
      3'd6:    alu_q = ~alu_op2;
      default: alu_q = alu_op1 + alu_op2;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      3'd1:    return a - b;
      3'd2:    return p[31:0];
      3'd3:    return a >> b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return ~b;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
    int k;
    k = 1;
    for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
    return (op == 3'd2) ? (1 + k) : 2;
  endfunction

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check_val("cmd_ready_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;
  endtask

  task automatic collect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] exp_q;
    int m;
    exp_q = ref_result(op, a, b);
    rsp_ready = (stall == 0);
    @(negedge clk);
    if (op == 3'd2) begin
      check_val("mul_alu_sel", 64'(alu_sel), 64'd0);
      check_val("mul_alu_op1", 64'(alu_op1), 64'd0);
      check_val("mul_alu_op2", 64'(alu_op2), 64'(a));
    end else begin
      check_val("exec_alu_sel", 64'(alu_sel), (op == 3'd7) ? 64'd0 : 64'(op));
      check_val("exec_alu_op1", 64'(alu_op1), 64'(a));
      check_val("exec_alu_op2", 64'(alu_op2), 64'(b));
    end
    m = 0;
    while (!rsp_valid && m < 40) begin
      @(negedge clk);
      m++;
    end
    if (!rsp_valid) begin
      check_val("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    check_val("latency", 64'(m + 1), 64'(ref_latency(op, b)));
    check_val("rsp_q", 64'(rsp_q), 64'(exp_q));
    check_val("rsp_zero", 64'(rsp_zero), 64'(exp_q == 32'd0));
    check_val("resp_alu_sel", 64'(alu_sel), 64'd0);
    check_val("resp_cmd_ready", 64'(cmd_ready), 64'd0);
`ifdef ALU_SEQ_ERR_EN
    check_val("rsp_err", 64'(rsp_err), 64'(op == 3'd7));
`endif
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_val("stall_valid", 64'(rsp_valid), 64'd1);
      check_val("stall_q", 64'(rsp_q), 64'(exp_q));
      check_val("stall_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_val("post_valid", 64'(rsp_valid), 64'd0);
    check_val("post_busy", 64'(busy), 64'd0);
    check_val("post_cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("idle_alu_sel", 64'(alu_sel), 64'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    send(op, a, b);
    collect(op, a, b, stall);
  endtask

  // Second command is held on the port while the first is still outstanding
  task automatic run_pair(input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1, input int stall,
                          input logic [2:0] op2, input logic [31:0] a2, input logic [31:0] b2);
    send(op1, a1, b1);
    cmd_valid = 1'b1; cmd_op = op2; cmd_a = a2; cmd_b = b2;
    collect(op1, a1, b1, stall);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = $urandom; cmd_b = $urandom;
    check_val("b2b_accept", 64'(busy), 64'd1);
    collect(op2, a2, b2, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        seen;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("reset_rsp_q", 64'(rsp_q), 64'd0);
    check_val("reset_rsp_zero", 64'(rsp_zero), 64'd1);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check_val("reset_alu_sel", 64'(alu_sel), 64'd0);
    check_val("reset_alu_op1", 64'(alu_op1), 64'd0);
    check_val("reset_alu_op2", 64'(alu_op2), 64'd0);
`ifdef ALU_SEQ_ERR_EN
    check_val("reset_rsp_err", 64'(rsp_err), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_reset", 64'(cmd_ready), 64'd1);

    run_op(3'd0, 32'd7, 32'd5, 0);
    run_op(3'd1, 32'd0, 32'd1, 0);
    run_op(3'd4, 32'h0000F0F0, 32'h0000FF00, 0);
    run_op(3'd6, 32'h12345678, 32'd0, 0);
    run_op(3'd3, 32'h80000000, 32'd31, 0);
    run_op(3'd5, 32'hA5000000, 32'h0000005A, 0);
    run_op(3'd2, 32'd3, 32'd5, 0);
    run_op(3'd2, 32'h00010000, 32'h00010000, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(3'd2, 32'hDEADBEEF, 32'd0, 0);
    run_op(3'd7, 32'd2, 32'd3, 0);
    run_op(3'd0, 32'd2, 32'd3, 0);

    run_pair(3'd0, 32'd1, 32'd1, 10, 3'd4, 32'hFFFF0000, 32'h0F0F0F0F);
    run_pair(3'd2, 32'd6, 32'd7, 0, 3'd1, 32'd10, 32'd3);

    // Reset during a long multiply must abort with no response
    send(3'd2, 32'd5, 32'h80000000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_cmd_ready_low", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("abort_alu_op2", 64'(alu_op2), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check_val("abort_no_rsp", 64'(seen), 64'd0);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (op == 3'd2) b = b >> $urandom_range(0, 31);
      if (op == 3'd3) b = 32'($urandom_range(0, 40));
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
